// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory-stage access controller.
// Holds bus widths, writeback data-select and register-op encodings,
// the memory-mapped UART addresses and the access FSM state encoding.
package mem_access_ctrl_pkg;

  localparam int unsigned DataW     = 16;
  localparam int unsigned RegAddrW  = 4;
  localparam int unsigned WbDataOpW = 2;
  localparam int unsigned RegOpW    = 2;
  localparam int unsigned RamAddrW  = 18;

  // Writeback data select encodings
  localparam logic [WbDataOpW-1:0] WbSelAlu = 2'd0;
  localparam logic [WbDataOpW-1:0] WbSelRam = 2'd1;
  localparam logic [WbDataOpW-1:0] WbSelPc  = 2'd2;
  localparam logic [WbDataOpW-1:0] WbSelIh  = 2'd3;

  localparam logic [RegOpW-1:0] RegOpNop = 2'd0;

  localparam logic [DataW-1:0] UartDataAddr = 16'hBF00;
  localparam logic [DataW-1:0] UartStatAddr = 16'hBF01;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StRd1  = 3'd1,
    StRd2  = 3'd2,
    StWr1  = 3'd3,
    StWr2  = 3'd4,
    StWr3  = 3'd5,
    StDone = 3'd6
  } state_e;

endpackage

// File: rtl/mem_wb_sel.sv
// Writeback data multiplexer for the MEM stage.
// Ports:
//   data_op  - writeback source select (ALU, RAM read data, PC, IH)
//   alu_data, rdata, pc, ih - candidate sources
//   wb_data  - selected writeback value
module mem_wb_sel
  import mem_access_ctrl_pkg::*;
(
  input  logic [WbDataOpW-1:0] data_op,
  input  logic [DataW-1:0]     alu_data,
  input  logic [DataW-1:0]     rdata,
  input  logic [DataW-1:0]     pc,
  input  logic [DataW-1:0]     ih,
  output logic [DataW-1:0]     wb_data
);

  always_comb begin
    wb_data = alu_data;
    unique case (data_op)
      WbSelAlu: wb_data = alu_data;
      WbSelRam: wb_data = rdata;
      WbSelPc:  wb_data = pc;
      WbSelIh:  wb_data = ih;
      default:  wb_data = alu_data;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: sequences SRAM (and optionally UART) reads and writes,
// stalls the front of the pipeline for the duration of an access and owns the
// MEM/WB pipeline register.
// Ports:
//   clk_50MHz, rst (async, active-low)
//   em_*        - EXE/MEM register contents; em_ALU_data doubles as address
//   ram_*       - external SRAM address/data/strobes (strobes active-low)
//   mem_stall   - holds PC/IF/ID/EXE/EXE_MEM while an access is in flight
//   mw_*        - MEM/WB register outputs
//   uart_*      - UART handshake, present only with UART_MMIO_EN defined
// Build option: define UART_MMIO_EN to map 0xBF00 (data) / 0xBF01 (status)
// onto the UART instead of SRAM.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
(
  input  logic                 clk_50MHz,
  input  logic                 rst,
  input  logic                 em_RAM_en,
  input  logic                 em_RAM_op,
  input  logic [WbDataOpW-1:0] em_DATA_op,
  input  logic [RegOpW-1:0]    em_REG_op,
  input  logic [DataW-1:0]     em_IH,
  input  logic [DataW-1:0]     em_PC,
  input  logic [DataW-1:0]     em_ALU_data,
  input  logic [DataW-1:0]     em_RAM_WB_data,
  input  logic [RegAddrW-1:0]  em_WB_addr,
  output logic [RamAddrW-1:0]  ram_addr,
  output logic [DataW-1:0]     ram_dout,
  input  logic [DataW-1:0]     ram_din,
  output logic                 ram_drive,
  output logic                 ram_ce_n,
  output logic                 ram_oe_n,
  output logic                 ram_we_n,
  output logic                 mem_stall,
  output logic [DataW-1:0]     mw_DATA,
  output logic [RegOpW-1:0]    mw_REG_op,
  output logic [RegAddrW-1:0]  mw_WB_addr
`ifdef UART_MMIO_EN
  ,
  output logic                 uart_rdn,
  output logic                 uart_wrn,
  input  logic                 uart_data_ready,
  input  logic                 uart_tbre
`endif
);

`ifdef UART_MMIO_EN
  localparam bit UartEn = 1'b1;
`else
  localparam bit UartEn = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [DataW-1:0] rdata_q;
  logic [DataW-1:0] rd_src;
  logic [DataW-1:0] wb_data;
  logic             is_uart_data, is_uart_stat, is_sram;
  logic             ce_n_q, oe_n_q, we_n_q, drive_q;

  // Address decode; em_ALU_data is held by the stall for the whole access.
  assign is_uart_data = UartEn && (em_ALU_data == UartDataAddr);
  assign is_uart_stat = UartEn && (em_ALU_data == UartStatAddr);
  assign is_sram      = !is_uart_data && !is_uart_stat;

`ifdef UART_MMIO_EN
  logic rdn_q, wrn_q;
  assign rd_src = is_uart_stat ? {14'b0, uart_data_ready, uart_tbre} : ram_din;
`else
  assign rd_src = ram_din;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (em_RAM_en) state_d = em_RAM_op ? StWr1 : StRd1;
      StRd1:  state_d = StRd2;
      StRd2:  state_d = StDone;
      StWr1:  state_d = StWr2;
      StWr2:  state_d = StWr3;
      StWr3:  state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign mem_stall = ((state_q == StIdle) && em_RAM_en) ||
                     (state_q inside {StRd1, StRd2, StWr1, StWr2, StWr3});

  // Strobes are registered from the next state so they are glitch-free and
  // line up exactly with the state they belong to.
  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      drive_q <= 1'b0;
      rdata_q <= '0;
`ifdef UART_MMIO_EN
      rdn_q   <= 1'b1;
      wrn_q   <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      ce_n_q  <= !(is_sram && (state_d inside {StRd1, StRd2, StWr1, StWr2, StWr3}));
      oe_n_q  <= !(is_sram && (state_d inside {StRd1, StRd2}));
      we_n_q  <= !(is_sram && (state_d == StWr2));
      // Status writes are dropped, so the bus is not driven for them.
      drive_q <= !is_uart_stat && (state_d inside {StWr1, StWr2, StWr3});
`ifdef UART_MMIO_EN
      rdn_q   <= !(is_uart_data && (state_d inside {StRd1, StRd2}));
      wrn_q   <= !(is_uart_data && (state_d == StWr2));
`endif
      if (state_q == StRd2) rdata_q <= rd_src;
    end
  end

  assign ram_ce_n  = ce_n_q;
  assign ram_oe_n  = oe_n_q;
  assign ram_we_n  = we_n_q;
  assign ram_drive = drive_q;
  assign ram_dout  = drive_q ? em_RAM_WB_data : '0;
  assign ram_addr  = (state_q != StIdle) ? {2'b00, em_ALU_data} : '0;

`ifdef UART_MMIO_EN
  assign uart_rdn = rdn_q;
  assign uart_wrn = wrn_q;
`endif

  mem_wb_sel u_mem_wb_sel (
    .data_op  (em_DATA_op),
    .alu_data (em_ALU_data),
    .rdata    (rdata_q),
    .pc       (em_PC),
    .ih       (em_IH),
    .wb_data  (wb_data)
  );

  // MEM/WB register: a stalled edge inserts a bubble and keeps the payload.
  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      mw_DATA    <= '0;
      mw_REG_op  <= RegOpNop;
      mw_WB_addr <= '0;
    end else if (mem_stall) begin
      mw_REG_op  <= RegOpNop;
    end else begin
      mw_DATA    <= wb_data;
      mw_REG_op  <= em_REG_op;
      mw_WB_addr <= em_WB_addr;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  logic        clk_50MHz = 1'b0;
  logic        rst = 1'b1;
  logic        em_RAM_en = 1'b0, em_RAM_op = 1'b0;
  logic [1:0]  em_DATA_op = '0, em_REG_op = '0;
  logic [15:0] em_IH = '0, em_PC = '0, em_ALU_data = '0, em_RAM_WB_data = '0;
  logic [3:0]  em_WB_addr = '0;
  logic [17:0] ram_addr;
  logic [15:0] ram_dout, ram_din = '0;
  logic        ram_drive, ram_ce_n, ram_oe_n, ram_we_n, mem_stall;
  logic [15:0] mw_DATA;
  logic [1:0]  mw_REG_op;
  logic [3:0]  mw_WB_addr;
`ifdef UART_MMIO_EN
  logic        uart_rdn, uart_wrn;
  logic        uart_data_ready = 1'b0, uart_tbre = 1'b0;
`endif

  always #10 clk_50MHz = ~clk_50MHz;

  mem_access_ctrl dut (
    .clk_50MHz      (clk_50MHz),
    .rst            (rst),
    .em_RAM_en      (em_RAM_en),
    .em_RAM_op      (em_RAM_op),
    .em_DATA_op     (em_DATA_op),
    .em_REG_op      (em_REG_op),
    .em_IH          (em_IH),
    .em_PC          (em_PC),
    .em_ALU_data    (em_ALU_data),
    .em_RAM_WB_data (em_RAM_WB_data),
    .em_WB_addr     (em_WB_addr),
    .ram_addr       (ram_addr),
    .ram_dout       (ram_dout),
    .ram_din        (ram_din),
    .ram_drive      (ram_drive),
    .ram_ce_n       (ram_ce_n),
    .ram_oe_n       (ram_oe_n),
    .ram_we_n       (ram_we_n),
    .mem_stall      (mem_stall),
    .mw_DATA        (mw_DATA),
    .mw_REG_op      (mw_REG_op),
    .mw_WB_addr     (mw_WB_addr)
`ifdef UART_MMIO_EN
    ,
    .uart_rdn        (uart_rdn),
    .uart_wrn        (uart_wrn),
    .uart_data_ready (uart_data_ready),
    .uart_tbre       (uart_tbre)
`endif
  );

  typedef struct {
    logic        en, op, dr, tbre;
    logic [1:0]  dop, rop;
    logic [15:0] ih, pc, alu, wdata, din;
    logic [3:0]  wb;
  } instr_t;

  int total = 0;
  int bad = 0;

  // Reference state: what MEM/WB must hold and the last value a load returned
  logic [15:0] exp_data = '0, last_rdata = '0;
  logic [1:0]  exp_rop = '0;
  logic [3:0]  exp_wb = '0;
  int stall_cnt, we_cnt, oe_cnt, ce_cnt, wrn_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic instr_t mk(input logic en, input logic op, input logic [1:0] dop,
                                input logic [1:0] rop, input logic [15:0] alu,
                                input logic [15:0] wdata, input logic [15:0] din,
                                input logic [3:0] wb);
    instr_t t;
    t.en = en; t.op = op; t.dop = dop; t.rop = rop; t.alu = alu;
    t.wdata = wdata; t.din = din; t.wb = wb;
    t.ih = 16'($urandom); t.pc = 16'($urandom);
    t.dr = 1'($urandom); t.tbre = 1'($urandom);
    return t;
  endfunction

  function automatic logic [15:0] wb_pick(input instr_t t, input logic [15:0] rd);
    logic [15:0] opts [4];
    opts[0] = t.alu; opts[1] = rd; opts[2] = t.pc; opts[3] = t.ih;
    return opts[t.dop];
  endfunction

  task automatic apply(input instr_t t);
    em_RAM_en = t.en; em_RAM_op = t.op; em_DATA_op = t.dop; em_REG_op = t.rop;
    em_IH = t.ih; em_PC = t.pc; em_ALU_data = t.alu; em_RAM_WB_data = t.wdata;
    em_WB_addr = t.wb; ram_din = t.din;
`ifdef UART_MMIO_EN
    uart_data_ready = t.dr; uart_tbre = t.tbre;
`endif
  endtask

  // Runs one instruction from presentation until EXE_MEM advances past it.
  // An access occupies stall cycles plus one DONE cycle; cycle k=0 is IDLE.
  task automatic run_instr(input instr_t t);
    int n;
    logic u_d, u_s, sram, rd_win, wr_win;
    logic [15:0] rd_val;
    apply(t);
    u_d = 1'b0; u_s = 1'b0;
`ifdef UART_MMIO_EN
    u_d = (t.alu == 16'hBF00);
    u_s = (t.alu == 16'hBF01);
`endif
    sram = !u_d && !u_s;
    n = !t.en ? 0 : (t.op ? 4 : 3);
    rd_val = u_s ? {14'b0, t.dr, t.tbre} : t.din;
    stall_cnt = 0; we_cnt = 0; oe_cnt = 0; ce_cnt = 0; wrn_cnt = 0;
    for (int k = 0; k <= n; k++) begin
      @(negedge clk_50MHz);
      rd_win = t.en && !t.op && (k == 1 || k == 2);
      wr_win = t.en && t.op && (k >= 1 && k <= 3);
      chk("mem_stall", 32'(mem_stall), 32'(k < n));
      chk("ram_ce_n", 32'(ram_ce_n), 32'(!(sram && (rd_win || wr_win))));
      chk("ram_oe_n", 32'(ram_oe_n), 32'(!(sram && rd_win)));
      chk("ram_we_n", 32'(ram_we_n), 32'(!(sram && wr_win && k == 2)));
      chk("ram_drive", 32'(ram_drive), 32'(!u_s && wr_win));
      chk("oe_drive_excl", 32'(!ram_oe_n && ram_drive), 32'(0));
      if (wr_win && !u_s) chk("ram_dout", 32'(ram_dout), 32'(t.wdata));
      if (k >= 1) chk("ram_addr", 32'(ram_addr), 32'({2'b00, t.alu}));
`ifdef UART_MMIO_EN
      chk("uart_rdn", 32'(uart_rdn), 32'(!(u_d && rd_win)));
      chk("uart_wrn", 32'(uart_wrn), 32'(!(u_d && wr_win && k == 2)));
      wrn_cnt += int'(!uart_wrn);
`endif
      chk("mw_DATA", 32'(mw_DATA), 32'(exp_data));
      chk("mw_REG_op", 32'(mw_REG_op), 32'(exp_rop));
      chk("mw_WB_addr", 32'(mw_WB_addr), 32'(exp_wb));
      stall_cnt += int'(mem_stall);
      we_cnt += int'(!ram_we_n);
      oe_cnt += int'(!ram_oe_n);
      ce_cnt += int'(!ram_ce_n);
      @(posedge clk_50MHz);
      if (t.en && !t.op && k == 2) last_rdata = rd_val;
      if (k < n) begin
        exp_rop = 2'd0;
      end else begin
        exp_data = wb_pick(t, last_rdata);
        exp_rop = t.rop;
        exp_wb = t.wb;
      end
      #1;
    end
  endtask

  initial begin
    instr_t t;
    #2 rst = 1'b0;
    #3;
    chk("rst_ce_n", 32'(ram_ce_n), 32'(1));
    chk("rst_oe_n", 32'(ram_oe_n), 32'(1));
    chk("rst_we_n", 32'(ram_we_n), 32'(1));
    chk("rst_drive", 32'(ram_drive), 32'(0));
    chk("rst_dout", 32'(ram_dout), 32'(0));
    chk("rst_mw_DATA", 32'(mw_DATA), 32'(0));
    chk("rst_mw_REG_op", 32'(mw_REG_op), 32'(0));
    chk("rst_mw_WB_addr", 32'(mw_WB_addr), 32'(0));
    chk("rst_stall", 32'(mem_stall), 32'(0));
`ifdef UART_MMIO_EN
    chk("rst_uart_rdn", 32'(uart_rdn), 32'(1));
    chk("rst_uart_wrn", 32'(uart_wrn), 32'(1));
`endif
    @(posedge clk_50MHz); #1 rst = 1'b1;

    // Load 0x1234 returning 0xBEEF
    run_instr(mk(1'b1, 1'b0, 2'd1, 2'd1, 16'h1234, 16'h0000, 16'hBEEF, 4'd2));
    chk("load_stall_cycles", 32'(stall_cnt), 32'(3));
    chk("load_oe_cycles", 32'(oe_cnt), 32'(2));
    chk("load_mw_DATA", 32'(mw_DATA), 32'(16'hBEEF));

    // Store 0x5A5A to 0x0040, immediately after the load
    run_instr(mk(1'b1, 1'b1, 2'd0, 2'd0, 16'h0040, 16'h5A5A, 16'h0000, 4'd0));
    chk("store_stall_cycles", 32'(stall_cnt), 32'(4));
    chk("store_we_cycles", 32'(we_cnt), 32'(1));
    chk("store_oe_cycles", 32'(oe_cnt), 32'(0));
    chk("store_ce_cycles", 32'(ce_cnt), 32'(3));

    // Plain ALU op
    run_instr(mk(1'b0, 1'b0, 2'd0, 2'd1, 16'h0007, 16'h0000, 16'h0000, 4'd3));
    chk("alu_stall_cycles", 32'(stall_cnt), 32'(0));
    chk("alu_mw_DATA", 32'(mw_DATA), 32'(16'h0007));
    chk("alu_mw_WB_addr", 32'(mw_WB_addr), 32'(3));
    chk("alu_mw_REG_op", 32'(mw_REG_op), 32'(1));

    // Back-to-back store then load
    run_instr(mk(1'b1, 1'b1, 2'd2, 2'd2, 16'h0100, 16'hC3C3, 16'h0000, 4'd4));
    run_instr(mk(1'b1, 1'b0, 2'd1, 2'd3, 16'h0101, 16'h0000, 16'h1357, 4'd5));
    chk("b2b_load_data", 32'(mw_DATA), 32'(16'h1357));

    // Randomized instruction stream
    for (int i = 0; i < 300; i++) begin
      t = mk(1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom), 16'($urandom),
             16'($urandom), 16'($urandom), 4'($urandom));
`ifdef UART_MMIO_EN
      if ($urandom_range(0, 3) == 0) t.alu = 16'hBF00 + 16'($urandom_range(0, 1));
`endif
      run_instr(t);
    end

    // Reset during the write pulse must abort the access at once
    apply(mk(1'b1, 1'b1, 2'd0, 2'd2, 16'h0200, 16'hA5A5, 16'h0000, 4'd5));
    @(posedge clk_50MHz); #1;
    @(posedge clk_50MHz); #1;
    chk("wr2_we_n_low", 32'(ram_we_n), 32'(0));
    #4 rst = 1'b0;
    #1;
    chk("abort_we_n", 32'(ram_we_n), 32'(1));
    chk("abort_drive", 32'(ram_drive), 32'(0));
    chk("abort_ce_n", 32'(ram_ce_n), 32'(1));
    chk("abort_mw_REG_op", 32'(mw_REG_op), 32'(0));
    chk("abort_mw_DATA", 32'(mw_DATA), 32'(0));
    em_RAM_en = 1'b0;
    exp_data = '0; exp_rop = '0; exp_wb = '0; last_rdata = '0;
    @(posedge clk_50MHz); #1 rst = 1'b1;
    run_instr(mk(1'b1, 1'b0, 2'd1, 2'd1, 16'h0300, 16'h0000, 16'h2468, 4'd6));
    chk("post_rst_load_stall", 32'(stall_cnt), 32'(3));
    chk("post_rst_load_data", 32'(mw_DATA), 32'(16'h2468));

`ifdef UART_MMIO_EN
    t = mk(1'b1, 1'b0, 2'd1, 2'd1, 16'hBF01, 16'h0000, 16'hFFFF, 4'd1);
    t.dr = 1'b1; t.tbre = 1'b0;
    run_instr(t);
    chk("uart_stat_data", 32'(mw_DATA), 32'(16'h0002));
    chk("uart_stat_ce_cycles", 32'(ce_cnt), 32'(0));
    run_instr(mk(1'b1, 1'b1, 2'd0, 2'd0, 16'hBF00, 16'h0041, 16'h0000, 4'd0));
    chk("uart_wrn_cycles", 32'(wrn_cnt), 32'(1));
    chk("uart_wr_ce_cycles", 32'(ce_cnt), 32'(0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have ports, in order:
- clk_50MHz  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
REQ-002 SHALL take EXE/MEM inputs:
- em_RAM_en  in  1  memory access requested.
- em_RAM_op  in  1  access type: 0 read, 1 write.
- em_DATA_op  in  2  WB data select.
- em_REG_op  in  2  WB register op; 0 = NOP.
- em_IH, em_PC, em_ALU_data, em_RAM_WB_data  in  16 each.
  - em_ALU_data is also the access address.
  - em_RAM_WB_data is the store data.
- em_WB_addr  in  4  writeback register.
REQ-003 SHALL have SRAM ports:
- ram_addr  out  18.
- ram_dout  out  16.
- ram_din  in  16.
- ram_drive  out  1  data-bus output enable.
- ram_ce_n, ram_oe_n, ram_we_n  out  1 each  active-low strobes.
REQ-004 SHALL have pipeline ports:
- mem_stall  out  1  holds PC/IF/ID/EXE/EXE_MEM.
- mw_DATA  out  16.
- mw_REG_op  out  2.
- mw_WB_addr  out  4.
REQ-005 With UART_MMIO_EN only, SHALL have UART ports:
- uart_rdn, uart_wrn  out  1 each.
- uart_data_ready, uart_tbre  in  1 each.

Function
REQ-006 FSM states: IDLE, RD1, RD2, WR1, WR2, WR3, DONE.
REQ-007 IDLE transitions:
- em_RAM_en=1 and em_RAM_op=0 -> RD1.
- em_RAM_en=1 and em_RAM_op=1 -> WR1.
- em_RAM_en=0 -> stay in IDLE.
REQ-008 Fixed transitions: RD1->RD2->DONE; WR1->WR2->WR3->DONE; DONE->IDLE unconditionally.
REQ-009 mem_stall is combinational:
- 1 in IDLE when em_RAM_en=1.
- 1 in RD1, RD2, WR1, WR2, WR3.
- 0 in DONE and in idle non-memory cycles.
- Load: 3 stall cycles. Store: 4 stall cycles.
REQ-010 ram_addr = {2'b00, em_ALU_data} in all non-IDLE states.
REQ-011 Read strobes:
- ram_ce_n=0 and ram_oe_n=0 in RD1 and RD2.
- ram_din latched into rdata_q on the RD2->DONE edge.
REQ-012 Write strobes:
- ram_ce_n=0 and ram_drive=1 in WR1, WR2, WR3.
- ram_dout = em_RAM_WB_data in those states.
- ram_we_n=0 in WR2 only.
- ram_oe_n=1 throughout.
REQ-013 ram_oe_n=0 and ram_drive=1 SHALL never occur together.
REQ-014 Writeback data select by em_DATA_op: 0 em_ALU_data, 1 rdata_q, 2 em_PC, 3 em_IH.
REQ-015 MEM/WB register update:
- Edge with mem_stall=0: mw_DATA, mw_REG_op, mw_WB_addr load the selected values.
- Edge with mem_stall=1: mw_REG_op loads 0 (bubble); mw_DATA and mw_WB_addr hold.
REQ-016 DONE lasts exactly one cycle. In it, EXE_MEM advances, so the same access is never issued twice.
REQ-017 Back-to-back accesses: a new em_RAM_en=1 seen in IDLE right after DONE starts a new access with no gap cycle.

Reset
REQ-018 While rst=0, immediately (asynchronously):
- state=IDLE.
- ram_ce_n, ram_oe_n, ram_we_n = 1; ram_drive=0; ram_dout=0.
- rdata_q=0; mw_DATA=0, mw_REG_op=0, mw_WB_addr=0.
- uart_rdn=1, uart_wrn=1.
REQ-019 Reset during any access SHALL abort it; no write pulse completes after rst falls.

Configuration
REQ-020 Macro UART_MMIO_EN, when defined:
- Addresses 0xBF00 (data) and 0xBF01 (status) bypass SRAM and use the same FSM states.
- ram_ce_n stays 1 for these accesses.
- Read 0xBF00: uart_rdn=0 in RD1 and RD2; ram_din sampled in RD2.
- Write 0xBF00: uart_wrn=0 in WR2; ram_drive=1 in WR1 to WR3.
- Read 0xBF01: no strobes; rdata_q = {14'b0, uart_data_ready, uart_tbre}.
- Write 0xBF01: ignored; no strobes, same stall timing.
REQ-021 When UART_MMIO_EN is undefined: UART ports are absent and all addresses go to SRAM.

Structure
REQ-022 Shared package/define file holds:
- Bus widths: DATA 16, REG_ADDR 4, WB_DATA_OP 2, REG_OP 2.
- WB_DATA_OP encodings and REG_OP_NOP.
- UART_DATA_ADDR 16'hBF00, UART_STAT_ADDR 16'hBF01.
- FSM state encodings.
REQ-023 One sub-module, mem_wb_sel, holds the combinational writeback mux; the FSM and registers live in mem_access_ctrl.

Verification
REQ-024 Load: em_RAM_en=1, op=0, ALU=0x1234, DATA_op=1, ram_din=0xBEEF.
- ram_addr=0x01234 with ce_n/oe_n low for 2 cycles.
- mem_stall high 3 cycles.
- mw_DATA=0xBEEF one edge after DONE.
REQ-025 Store: em_RAM_en=1, op=1, ALU=0x0040, WB_data=0x5A5A.
- ram_we_n low exactly 1 cycle (WR2); ram_dout=0x5A5A in WR1 to WR3.
- mem_stall 4 cycles; oe_n stays 1.
REQ-026 ALU op: em_RAM_en=0, DATA_op=0, ALU=0x0007, WB_addr=3, REG_op=1.
- mem_stall=0.
- Next edge: mw_DATA=0x0007, mw_WB_addr=3, mw_REG_op=1.
REQ-027 Back-to-back store then load: no IDLE gap after DONE; bubbles on mw_REG_op=0 during each stall.
REQ-028 rst=0 asserted in WR2: ram_we_n=1 and ram_drive=0 within the same cycle; state IDLE after release.
REQ-029 UART_MMIO_EN: read 0xBF01 with data_ready=1, tbre=0 -> mw_DATA=0x0002, ram_ce_n stays 1; write 0xBF00 -> uart_wrn low 1 cycle.
